// File: rtl/data_mem_resp_if.sv
// Load/store request bus between the core (master) and the data-memory responder (slave).
// Carries the request strobe, access attributes, and the ack/data/error/busy response.
interface data_mem_resp_if;
  logic        iReq;
  logic        iWe;
  logic [31:0] iAddr;
  logic [31:0] iWrData;
  logic [2:0]  iFunct3;
  logic        oAck;
  logic [31:0] oRdData;
  logic        oErr;
  logic        oBusy;

  modport master (
    output iReq, iWe, iAddr, iWrData, iFunct3,
    input  oAck, oRdData, oErr, oBusy
  );

  modport slave (
    input  iReq, iWe, iAddr, iWrData, iFunct3,
    output oAck, oRdData, oErr, oBusy
  );
endinterface

// File: rtl/data_mem_resp.sv
// RV32I data-memory responder: one request at a time, WAIT_CYC wait states, one-cycle ack.
// Define DMEM_ALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of force-aligning.
module data_mem_resp #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input logic            iClk,
  input logic            iRst,
  data_mem_resp_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         AW      = ADDR_W + 2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     rd_q, rd_d;
  logic            err_q, err_d;
  logic [31:0]     mem [2**ADDR_W];

  logic            accept, commit, c_we, illegal, bad;
  logic [AW-1:0]   c_addr;
  logic [31:0]     c_wdata, word;
  logic [2:0]      c_f3;
  logic [1:0]      lo;
  logic [ADDR_W-1:0] idx;
  logic            unused_addr;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] bo,
                                           input logic [2:0] f3);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = w >> {bo, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] bo, input logic [1:0] sz);
    logic [3:0]  be;
    logic [31:0] rep, res;
    case (sz)
      2'b00:   begin be = 4'b0001 << bo;                  rep = {4{wd[7:0]}};  end
      2'b01:   begin be = bo[1] ? 4'b1100 : 4'b0011;      rep = {2{wd[15:0]}}; end
      default: begin be = 4'b1111;                        rep = wd;            end
    endcase
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = rep[8*i +: 8];
    end
    return res;
  endfunction

  // state register
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (bus.iReq) begin
        cnt_d   = WAIT_LD;
        state_d = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
              else               cnt_d   = cnt_q - 4'd1;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // request capture and access datapath; with zero wait states the live inputs are used directly
  always_comb begin
    accept  = (state_q == S_IDLE) && bus.iReq;
    commit  = (state_d == S_RESP) && (state_q != S_RESP);
    we_d    = accept ? bus.iWe           : we_q;
    addr_d  = accept ? bus.iAddr[AW-1:0] : addr_q;
    wdata_d = accept ? bus.iWrData       : wdata_q;
    f3_d    = accept ? bus.iFunct3       : f3_q;
    c_we    = accept ? bus.iWe           : we_q;
    c_addr  = accept ? bus.iAddr[AW-1:0] : addr_q;
    c_wdata = accept ? bus.iWrData       : wdata_q;
    c_f3    = accept ? bus.iFunct3       : f3_q;
    idx     = c_addr[AW-1:2];
    word    = mem[idx];
    illegal = (c_f3 == 3'b011) || (c_f3 == 3'b110) || (c_f3 == 3'b111) || (c_we && c_f3[2]);
`ifdef DMEM_ALIGN_TRAP_EN
    bad     = illegal || (c_f3[1:0] == 2'b01 && c_addr[0])
                      || (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00);
    lo      = c_addr[1:0];
`else
    bad     = illegal;
    case (c_f3[1:0])
      2'b01:   lo = {c_addr[1], 1'b0};
      2'b10:   lo = 2'b00;
      default: lo = c_addr[1:0];
    endcase
`endif
    rd_d    = (commit && !bad && !c_we) ? load_ext(word, lo, c_f3) : '0;
    err_d   = commit && bad;
  end

  assign unused_addr = ^bus.iAddr[31:AW];

  always_ff @(posedge iClk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    f3_q    <= f3_d;
  end

  // store commits on the edge that enters RESP
  always_ff @(posedge iClk) begin
    if (iRst && commit && c_we && !bad) mem[idx] <= store_merge(word, c_wdata, lo, c_f3[1:0]);
  end

  // outputs
  always_comb begin
    bus.oAck    = (state_q == S_RESP);
    bus.oBusy   = (state_q != S_IDLE);
    bus.oRdData = rd_q;
    bus.oErr    = err_q;
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed load/store vectors, a transaction-level reference model
// checked every cycle, and literal expectations for the key vectors.
module tb_data_mem_resp;
  localparam int W  = 1;
  localparam int AW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  data_mem_resp_if bus();
  data_mem_resp #(.ADDR_W(AW), .WAIT_CYC(W)) dut (.iClk(clk), .iRst(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        err;
    logic [31:0] rd;
    logic        wr;
    logic [31:0] idx;
    logic [31:0] nw;
  } res_t;

  logic [31:0] mm [2**AW];

  function automatic res_t model_calc(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic [2:0] f3);
    res_t        r;
    int unsigned a, o, size;
    bit          illegal, mis;
    logic [31:0] old;
    longint      v;
    r       = '0;
    size    = 32'(f3[1:0]);
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
    mis     = (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
    a = addr;
    if (size == 1) a = a - a % 2;
    if (size == 2) a = a - a % 4;
`ifdef DMEM_ALIGN_TRAP_EN
    r.err = illegal || mis;
`else
    r.err = illegal;
`endif
    r.idx = (a / 4) % (2**AW);
    o     = a % 4;
    old   = mm[r.idx[AW-1:0]];
    if (r.err) return r;
    if (we) begin
      r.wr = 1'b1;
      r.nw = old;
      if (size == 0)      r.nw[8*o +: 8]  = wd[7:0];
      else if (size == 1) r.nw[8*o +: 16] = wd[15:0];
      else                r.nw = wd;
    end else begin
      v = longint'(old >> (8*o));
      if (size == 0) begin
        v = v % 256;
        if (f3 == 3'd0 && v >= 128) v -= 256;
      end else if (size == 1) begin
        v = v % 65536;
        if (f3 == 3'd1 && v >= 32768) v -= 65536;
      end
      r.rd = v[31:0];
    end
    return r;
  endfunction

  int          cyc = 0;
  int          acc = 0;
  bit          pending = 1'b0;
  bit          wr_pend = 1'b0;
  logic [31:0] wr_idx, wr_val, exp_rd;
  logic        exp_err;
  logic        exp_busy, exp_ack;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      wr_pend <= 1'b0;
    end else begin
      automatic res_t r;
      cyc <= cyc + 1;
      if (!(pending && (cyc - acc) <= W) && bus.iReq) begin
        r = model_calc(bus.iWe, bus.iAddr, bus.iWrData, bus.iFunct3);
        pending <= 1'b1;
        acc     <= cyc + 1;
        exp_rd  <= r.rd;
        exp_err <= r.err;
        if (r.wr) begin
          if (W == 0) mm[r.idx[AW-1:0]] <= r.nw;
          else begin
            wr_pend <= 1'b1;
            wr_idx  <= r.idx;
            wr_val  <= r.nw;
          end
        end
      end else if (pending && (cyc + 1 - acc) > W) begin
        pending <= 1'b0;
      end
      if (wr_pend && (cyc + 1 - acc) == W) begin
        mm[wr_idx[AW-1:0]] <= wr_val;
        wr_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    exp_busy = pending && ((cyc - acc) <= W);
    exp_ack  = pending && ((cyc - acc) == W);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_busy", 32'(bus.oBusy), 32'(exp_busy));
      check("mon_ack",  32'(bus.oAck),  32'(exp_ack));
      check("mon_rd",   bus.oRdData,    exp_ack ? exp_rd : 32'h0);
      check("mon_err",  32'(bus.oErr),  32'(exp_ack ? exp_err : 1'b0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rd, output logic err,
                        output int lat);
    @(negedge clk);
    bus.iReq = 1'b1; bus.iWe = we; bus.iAddr = addr; bus.iWrData = wd; bus.iFunct3 = f3;
    @(negedge clk);
    bus.iReq = 1'b0;
    lat = 1; rd = '0; err = 1'b0;
    while (!bus.oAck && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (bus.oAck) begin
      rd  = bus.oRdData;
      err = bus.oErr;
    end else lat = -1;
  endtask

  task automatic txn_chk(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] f3,
                         input logic [31:0] erd, input logic eerr);
    logic [31:0] rd;
    logic        err;
    int          lat;
    do_txn(we, addr, wd, f3, rd, err, lat);
    check({name, "_lat"}, 32'(lat), 32'(W + 1));
    check({name, "_rd"},  rd, erd);
    check({name, "_err"}, 32'(err), 32'(eerr));
  endtask

  task automatic busy_run(input string name, input int hold, input int exp_acks,
                          input int exp_last);
    int acks, last;
    acks = 0; last = -1;
    @(negedge clk);
    bus.iReq = 1'b1; bus.iWe = 1'b0; bus.iAddr = 32'h20; bus.iFunct3 = 3'b010;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.oAck) begin
        acks++;
        last = i;
      end
      if (i == hold) bus.iReq = 1'b0;
    end
    check({name, "_acks"}, 32'(acks), 32'(exp_acks));
    check({name, "_last"}, 32'(last), 32'(exp_last));
  endtask

  initial begin
    bus.iReq = 1'b0; bus.iWe = 1'b0; bus.iAddr = '0; bus.iWrData = '0; bus.iFunct3 = '0;
    #1 rst_n = 1'b0;
    #1 mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack",  32'(bus.oAck),  32'h0);
    check("rst_busy", 32'(bus.oBusy), 32'h0);
    check("rst_rd",   bus.oRdData,    32'h0);
    check("rst_err",  32'(bus.oErr),  32'h0);
    rst_n = 1'b1;

    // reset during WAIT aborts a pending store
    txn_chk("sw0_10", 1'b1, 32'h10, 32'h0, 3'b010, 32'h0, 1'b0);
    @(negedge clk);
    bus.iReq = 1'b1; bus.iWe = 1'b1; bus.iAddr = 32'h10; bus.iWrData = 32'hDEADBEEF;
    bus.iFunct3 = 3'b010;
    @(negedge clk);
    bus.iReq = 1'b0;
    check("abort_busy_pre", 32'(bus.oBusy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.oBusy), 32'h0);
    check("abort_ack",  32'(bus.oAck),  32'h0);
    check("abort_rd",   bus.oRdData,    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    txn_chk("lw_after_abort", 1'b0, 32'h10, 32'h0, 3'b010, 32'h0, 1'b0);

    // word store/load and aliasing
    txn_chk("sw_20",    1'b1, 32'h20,   32'h12345678, 3'b010, 32'h0,        1'b0);
    txn_chk("lw_20",    1'b0, 32'h20,   32'h0,        3'b010, 32'h12345678, 1'b0);
    txn_chk("lw_alias", 1'b0, 32'h1020, 32'h0,        3'b010, 32'h12345678, 1'b0);

    // byte lanes
    txn_chk("sw_40",  1'b1, 32'h40, 32'h0,        3'b010, 32'h0,        1'b0);
    txn_chk("sb_43",  1'b1, 32'h43, 32'hAAAAAA80, 3'b000, 32'h0,        1'b0);
    txn_chk("lb_43",  1'b0, 32'h43, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0);
    txn_chk("lbu_43", 1'b0, 32'h43, 32'h0,        3'b100, 32'h00000080, 1'b0);
    txn_chk("lbu_40", 1'b0, 32'h40, 32'h0,        3'b100, 32'h00000000, 1'b0);

    // halfwords
    txn_chk("sh_42",  1'b1, 32'h42, 32'h55558001, 3'b001, 32'h0,        1'b0);
    txn_chk("lh_42",  1'b0, 32'h42, 32'h0,        3'b001, 32'hFFFF8001, 1'b0);
    txn_chk("lhu_42", 1'b0, 32'h42, 32'h0,        3'b101, 32'h00008001, 1'b0);
    txn_chk("lw_40",  1'b0, 32'h40, 32'h0,        3'b010, 32'h80010000, 1'b0);

    // busy: request held 3 cycles gives one ack; held 4 gives a second accept after ack falls
    busy_run("busy3", 3, 1, 2);
    busy_run("busy4", 4, 2, 5);

    // errors
    txn_chk("ld_f3_011", 1'b0, 32'h20, 32'h0,        3'b011, 32'h0,        1'b1);
    txn_chk("st_f3_100", 1'b1, 32'h20, 32'hFFFFFFFF, 3'b100, 32'h0,        1'b1);
    txn_chk("lw_20_kept", 1'b0, 32'h20, 32'h0,       3'b010, 32'h12345678, 1'b0);
`ifdef DMEM_ALIGN_TRAP_EN
    txn_chk("lw_22",  1'b0, 32'h22, 32'h0,        3'b010, 32'h0, 1'b1);
    txn_chk("lh_43",  1'b0, 32'h43, 32'h0,        3'b001, 32'h0, 1'b1);
    txn_chk("sw_22",  1'b1, 32'h22, 32'hCAFEF00D, 3'b010, 32'h0, 1'b1);
    txn_chk("lw_20_after_sw22", 1'b0, 32'h20, 32'h0, 3'b010, 32'h12345678, 1'b0);
`else
    txn_chk("lw_22",  1'b0, 32'h22, 32'h0,        3'b010, 32'h12345678, 1'b0);
    txn_chk("lh_43",  1'b0, 32'h43, 32'h0,        3'b001, 32'hFFFF8001, 1'b0);
    txn_chk("sw_22",  1'b1, 32'h22, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0);
    txn_chk("lw_20_after_sw22", 1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
